// File: rtl/ysyx_041461_imem_pkg.sv
// Shared definitions for the fetch-side instruction memory and the PC register.
package ysyx_041461_imem_pkg;

  typedef enum logic [1:0] {
    ysyx_041461_IMEM_IDLE = 2'd0,
    ysyx_041461_IMEM_BUSY = 2'd1,
    ysyx_041461_IMEM_RESP = 2'd2
  } imem_state_e;

  localparam logic [63:0] ysyx_041461_PC_RESET = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_041461_imem_array.sv
// Word array with synchronous preload write and a combinational read port that
// the top samples at the acceptance edge, so a same-edge write returns the old word.
module ysyx_041461_imem_array #(
  parameter  int unsigned DEPTH = 4096,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ysyx_041461_if_imem.sv
// Fixed-latency instruction memory responder with valid/ready response and flush.
//   state | meaning
//   IDLE  | waiting for a fetch request
//   BUSY  | counting down the remaining latency
//   RESP  | response presented, held until resp_ready
module ysyx_041461_if_imem
  import ysyx_041461_imem_pkg::*;
#(
  parameter  int unsigned LATENCY = 2,
  parameter  int unsigned DEPTH   = 4096,
  parameter  logic [63:0] BASE    = ysyx_041461_PC_RESET,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_pc,
  input  logic          flush,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_inst,
  output logic [63:0]   resp_pc,
  output logic          resp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data
);

  imem_state_e   state;
  logic [3:0]    cnt;
  logic [63:0]   offset;
  logic          err;
  logic          accept;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;

  assign req_ready = (state == ysyx_041461_IMEM_IDLE) && !flush && rst_n;
  assign accept    = req_valid && req_ready;

  // Addresses below BASE wrap to huge offsets and fall out of range.
  assign offset = req_pc - BASE;
  assign err    = (req_pc[1:0] != 2'b00) || (offset >= 64'(DEPTH) * 64'd4);
  assign rd_idx = offset[AW+1:2];

  ysyx_041461_imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ysyx_041461_IMEM_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_inst  <= '0;
      resp_pc    <= '0;
      resp_err   <= 1'b0;
    end else if (flush) begin
      state      <= ysyx_041461_IMEM_IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        ysyx_041461_IMEM_IDLE: begin
          if (accept) begin
            resp_pc   <= req_pc;
            resp_err  <= err;
            resp_inst <= err ? 32'h0 : rd_data;
            if (LATENCY == 1) begin
              state      <= ysyx_041461_IMEM_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ysyx_041461_IMEM_BUSY;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        ysyx_041461_IMEM_BUSY: begin
          if (cnt == 4'd0) begin
            state      <= ysyx_041461_IMEM_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ysyx_041461_IMEM_RESP: begin
          if (resp_ready) begin
            state      <= ysyx_041461_IMEM_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ysyx_041461_IMEM_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_if_imem.sv
// Scoreboard bench: three responders (LATENCY 2, 4, 1) driven by directed and random fetches.
module tb_ysyx_041461_if_imem;
  import ysyx_041461_imem_pkg::*;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [63:0] BASE  = ysyx_041461_PC_RESET;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 4 : 1;

    logic          rst_n, req_valid, req_ready, flush, resp_valid, resp_ready, resp_err, ld_en;
    logic [63:0]   req_pc, resp_pc;
    logic [31:0]   resp_inst, ld_data;
    logic [AW-1:0] ld_idx;

    logic [31:0] mdl [DEPTH];
    exp_t        q[$];
    bit          acc_flag;

    ysyx_041461_if_imem #(.LATENCY(LAT), .DEPTH(DEPTH), .BASE(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pc     (req_pc),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_inst  (resp_inst),
      .resp_pc    (resp_pc),
      .resp_err   (resp_err),
      .ld_en      (ld_en),
      .ld_idx     (ld_idx),
      .ld_data    (ld_data)
    );

    task automatic c(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("L%0d_%s", LAT, name), act, exp);
    endtask

    // Reference: a fetch is legal only if word aligned and inside [BASE, BASE+DEPTH*4).
    function automatic exp_t model(input logic [63:0] pc, input int acc);
      exp_t e;
      e.pc   = pc;
      e.acc  = acc;
      e.err  = (pc % 4 != 0) || (pc < BASE) || (pc >= BASE + 64'(DEPTH * 4));
      e.inst = e.err ? 32'h0 : mdl[int'((pc - BASE) / 4)];
      return e;
    endfunction

    task automatic drive(input bit rv, input logic [63:0] pc, input bit fl, input bit rr,
                         input bit le, input logic [AW-1:0] li, input logic [31:0] ld);
      @(negedge clk);
      req_valid  = rv;
      req_pc     = pc;
      flush      = fl;
      resp_ready = rr && !fl;
      ld_en      = le;
      ld_idx     = li;
      ld_data    = ld;
      #1;
      if (fl) q.delete();
      acc_flag = rv && req_ready;
      if (acc_flag) q.push_back(model(pc, cyc + 1));
      if (le) mdl[li] = ld;
    endtask

    task automatic drain(input int hold);
      int n;
      n = 0;
      while ((q.size() != 0 || resp_valid) && n < 40) begin
        drive(1'b0, '0, 1'b0, hold == 0, 1'b0, '0, '0);
        if (resp_valid && hold > 0) hold--;
        n++;
      end
      c("resp_timeout", 64'(n >= 40), 64'(0));
    endtask

    task automatic fetch(input logic [63:0] pc, input int hold);
      int n;
      n = 0;
      do begin
        drive(1'b1, pc, 1'b0, 1'b0, 1'b0, '0, '0);
        n++;
      end while (!acc_flag && n < 20);
      c("accept_timeout", 64'(acc_flag), 64'(1));
      drain(hold);
    endtask

    // Driver
    initial begin
      logic [63:0] pc;
      int          k;
      rst_n = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0; resp_ready = 1'b0;
      ld_en = 1'b0; ld_idx = '0; ld_data = '0;
      #1 rst_n = 1'b0;
      #2;
      c("rst_valid", resp_valid, 0);
      c("rst_ready", req_ready, 0);
      c("rst_inst", resp_inst, 0);
      c("rst_pc", resp_pc, 0);
      c("rst_err", resp_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++)
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(i),
              (i == 0) ? 32'h0000_0297 : (i == 1) ? 32'h0082_8293 : $urandom);

      fetch(BASE, 0);
      fetch(BASE + 64'd4, 0);
      fetch(BASE + 64'd2, 0);
      fetch(BASE - 64'd4, 0);
      fetch(BASE + 64'(DEPTH * 4), 0);
      fetch(BASE + 64'd8, 5);

      // Flush right after an accept: the presented request must be refused.
      drive(1'b1, BASE + 64'd12, 1'b0, 1'b0, 1'b0, '0, '0);
      c("pre_flush_accept", 64'(acc_flag), 1);
      drive(1'b1, BASE + 64'd16, 1'b1, 1'b0, 1'b0, '0, '0);
      c("flush_no_accept", 64'(acc_flag), 0);
      drive(1'b1, BASE + 64'd16, 1'b0, 1'b0, 1'b0, '0, '0);
      c("post_flush_accept", 64'(acc_flag), 1);
      drain(0);

      // Same-cycle preload to the word being fetched returns the old word.
      drive(1'b1, BASE + 64'd32, 1'b0, 1'b0, 1'b1, AW'(8), 32'hDEAD_BEEF);
      c("ld_accept", 64'(acc_flag), 1);
      drain(0);
      fetch(BASE + 64'd32, 0);

      // Asynchronous reset between edges while a fetch is in flight.
      drive(1'b1, BASE, 1'b0, 1'b0, 1'b0, '0, '0);
      c("rst_mid_accept", 64'(acc_flag), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      c("arst_valid", resp_valid, 0);
      c("arst_ready", req_ready, 0);
      c("arst_inst", resp_inst, 0);
      c("arst_pc", resp_pc, 0);
      c("arst_err", resp_err, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      fetch(BASE, 0);

      repeat (150) begin
        k  = $urandom_range(0, 9);
        pc = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
        if (k == 0) pc = pc + 64'($urandom_range(1, 3));
        else if (k == 1) pc = BASE - 64'($urandom_range(1, 8)) * 64'd4;
        else if (k == 2) pc = BASE + 64'(DEPTH * 4) + 64'($urandom_range(0, 8)) * 64'd4;
        drive(1'($urandom_range(0, 1)), pc, $urandom_range(0, 15) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, AW'($urandom), $urandom);
      end
      drain(0);
      done[g] = 1'b1;
    end

    // Monitor
    initial begin
      bit   pv, phs, pfl;
      exp_t e;
      pv = 1'b0; phs = 1'b0; pfl = 1'b0;
      forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
          pv = 1'b0; phs = 1'b0; pfl = 1'b0;
          continue;
        end
        if (pfl && !flush) begin
          c("flush_valid", resp_valid, 0);
          c("flush_ready", req_ready, 1);
        end
        if (phs) begin
          c("hs_idle_valid", resp_valid, 0);
          c("hs_idle_ready", req_ready, 64'(!flush));
        end
        if (resp_valid && !flush) begin
          if (q.size() == 0) begin
            c("spurious_valid", resp_valid, 0);
          end else begin
            e = q[0];
            if (!pv || phs) c("latency", 64'(cyc - e.acc), 64'(LAT - 1));
            c("inst", resp_inst, e.inst);
            c("pc", resp_pc, e.pc);
            c("err", resp_err, e.err);
            if (resp_ready) void'(q.pop_front());
            else c("hold_ready", req_ready, 0);
          end
        end
        pv  = resp_valid && !flush;
        phs = pv && resp_ready;
        pfl = flush;
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      errors++;
      $display("FAIL global_timeout actual=%0d required=<20000 cycles", n);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_if_imem.md
# ysyx_041461_IF_imem

Instruction-memory responder at the far end of the fetch path. It accepts the fetch address produced by the PC register and, after a fixed latency, returns the 32-bit instruction through a valid/ready handshake. Pipeline redirects discard in-flight fetches. A preload port fills the array before or during simulation.

## Interface
Parameters:
- LATENCY, 2, cycles from request acceptance to first `resp_valid`; legal range 1..15.
- DEPTH, 4096, array size in 32-bit words; must be a power of two.
- BASE, 64'h0000_0000_8000_0000, byte address of word 0; equals the PC reset value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept; equals (state==IDLE) && !flush && rst_n.
- req_pc  in  64  fetch byte address.
- flush  in  1  redirect from ID/WB; kills the in-flight fetch.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_inst  out  32  instruction word.
- resp_pc  out  64  address of `resp_inst`.
- resp_err  out  1  misaligned or out-of-range fetch.
- ld_en  in  1  preload write enable.
- ld_idx  in  log2(DEPTH)  preload word index.
- ld_data  in  32  preload data.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - A request is accepted when `req_valid && req_ready`.
  - At acceptance, latch `req_pc` into `resp_pc`.
  - Compute `err = (req_pc[1:0]!=0) || (req_pc-BASE >= DEPTH*4)`, using unsigned 64-bit subtraction so addresses below BASE wrap and count as errors.
  - Latch `resp_inst = err ? 32'h0 : mem[(req_pc-BASE)>>2]`. The array is read at the acceptance edge.
  - Next state: RESP if LATENCY==1; otherwise BUSY with `cnt = LATENCY-2`.
- **BUSY**
  - If `cnt==0`, go to RESP; otherwise decrement `cnt`.
  - `req_ready` is 0.
- **RESP**
  - `resp_valid` is 1; `resp_*` outputs are held stable.
  - On `resp_ready`, go to IDLE. There is no accept in the same cycle; the next request is accepted no earlier than the following cycle.
- **flush**
  - Highest priority: from any state, next state is IDLE and `resp_valid` is 0 in the following cycle.
  - A request presented in the flush cycle is not accepted.
  - `resp_pc`, `resp_inst` and `resp_err` keep their stale values.
- **Preload**
  - On `ld_en`, `mem[ld_idx] <= ld_data` in any state.
  - A preload to the index being read in the same acceptance cycle returns the old word.
  - Already-latched responses are unaffected.
  - The array is not reset.
- **Reset** (`rst_n` low, async, including mid-transaction)
  - state=IDLE, cnt=0, resp_valid=0, resp_inst=0, resp_pc=0, resp_err=0.
  - `req_ready` is 0 while `rst_n` is low.

## Timing
- An accept at edge E gives `resp_valid` high after edge E+LATENCY-1 (visible in cycle E+LATENCY).
- Throughput is one fetch per LATENCY+1 cycles when `resp_ready` is constantly 1.
- Flush asserted in cycle C gives `resp_valid`=0 and `req_ready`=1 in cycle C+1, provided `flush` has deasserted.
- `req_ready` is the only combinational output.

## Structure
- Shared package/defines file:
  - `ysyx_041461_IMEM_IDLE/BUSY/RESP` state encodings (2 bits).
  - `ysyx_041461_PC_RESET` constant (64'h8000_0000), also used by the PC register.
- One natural sub-module: `ysyx_041461_imem_array`, a synchronous-write, read-at-acceptance 32-bit word array with a `DEPTH` parameter.
- The FSM, counter and response registers live in the top module.

## Test plan
- Preload `mem[0]`=32'h0000_0297, `mem[1]`=32'h0082_8293. With LATENCY=2, request pc 8000_0000 then 8000_0004 with `resp_ready`=1:
  - first response `resp_inst`=0000_0297, `resp_pc`=8000_0000, 2 cycles after accept;
  - second response 0082_8293.
- Request pc 8000_0002 -> `resp_err`=1, `resp_inst`=0. Request pc 7FFF_FFFC -> `resp_err`=1. Request pc BASE+DEPTH*4 -> `resp_err`=1.
- Hold `resp_ready`=0 for 5 cycles in RESP -> `resp_valid`, `resp_inst` and `resp_pc` stay constant and `req_ready` stays 0. After `resp_ready` rises -> IDLE one cycle later.
- Assert `flush` in BUSY (LATENCY=4) with `req_valid`=1 -> no accept that cycle, `resp_valid` never rises for the killed fetch, and a new request is accepted in the next cycle.
- Drop `rst_n` mid-BUSY asynchronously (between edges) -> outputs go to zero immediately. After release, a request for pc 8000_0000 returns the preserved `mem[0]`.
- LATENCY=1: accept then `resp_valid` in the next cycle. A same-cycle preload to the requested index returns the old data.
